// File: rtl/locked_intc_pkg.sv
// -----------------------------------------------------------------------------
// locked_intc_pkg
// Shared types and constants for the key-locked priority interrupt controller:
//   - state_t      : controller state (LOAD, CHECK, RUN)
//   - DEF_KEY_W    : default key length in bits
//   - id_width()   : channel-ID width for a given channel count
// -----------------------------------------------------------------------------
package locked_intc_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int DEF_KEY_W = 64;

    // Width needed to encode channel indices 0..n-1 (never below one bit).
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_arbiter.sv
// -----------------------------------------------------------------------------
// prio_arbiter
// Combinational find-first-set: reports the lowest-index asserted request.
// Ports:
//   req  in  NCH   request vector
//   any  out 1     at least one request asserted
//   id   out ID_W  index of the lowest asserted request (0 when none)
// -----------------------------------------------------------------------------
module prio_arbiter #(
    parameter int NCH  = 27,
    parameter int ID_W = 5
) (
    input  logic [NCH-1:0]  req,
    output logic            any,
    output logic [ID_W-1:0] id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        any = 1'b0;
        id  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            any = any | req[i];
            id  = req[i] ? ID_W'(i) : id;
        end
    end

endmodule

// File: rtl/locked_prio_intc.sv
// -----------------------------------------------------------------------------
// locked_prio_intc
// Sequential key-locked priority interrupt controller. A key is shifted in
// LSB first, checked once, and then the controller arbitrates latched
// interrupt requests (lowest unmasked index wins) and presents one grant at
// a time over a valid/ack handshake. With a wrong key it keeps running, but
// the presented ID is XOR-corrupted by the low key bits that differ.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   irq_i         level interrupt requests, latched into the pending register
//   mask_i        1 = channel excluded from arbitration
//   key_bit_i     serial key bit (LSB first), qualified by key_valid_i
//   key_valid_i   key bit qualifier
//   key_last_i    final key bit marker (with key_valid_i)
//   key_clear_i   discard key and return to LOAD
//   key_ready_o   high while loading the key
//   unlocked_o    loaded key matched KEY_VAL
//   int_valid_o   a granted interrupt is presented
//   int_id_o      presented channel ID (corrupted when locked)
//   int_ack_i     consumer acknowledge
// -----------------------------------------------------------------------------
module locked_prio_intc
    import locked_intc_pkg::*;
#(
    parameter int               NCH     = 27,
    parameter int               ID_W    = id_width(NCH),
    parameter int               KEY_W   = DEF_KEY_W,
    parameter logic [KEY_W-1:0] KEY_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  irq_i,
    input  logic [NCH-1:0]  mask_i,
    input  logic            key_bit_i,
    input  logic            key_valid_i,
    input  logic            key_last_i,
    input  logic            key_clear_i,
    output logic            key_ready_o,
    output logic            unlocked_o,
    output logic            int_valid_o,
    output logic [ID_W-1:0] int_id_o,
    input  logic            int_ack_i
);

    localparam int              CNT_W   = $clog2(KEY_W + 1);
    localparam logic [ID_W-1:0] KEY_LOW = KEY_VAL[ID_W-1:0];

    state_t           r_state;
    logic [KEY_W-1:0] r_key;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_unlocked;
    logic             r_key_ready;
    logic             r_int_valid;
    logic [ID_W-1:0]  r_int_id;
    logic [ID_W-1:0]  r_true_id;
    logic [NCH-1:0]   r_pend;

    logic [NCH-1:0]   w_req;
    logic             w_any;
    logic [ID_W-1:0]  w_id;
    logic             w_hs;
    logic             w_key_done;
    logic [NCH-1:0]   w_clr_vec;

    assign w_req      = r_pend & ~mask_i;
    assign w_hs       = r_int_valid & int_ack_i;
    // Leave LOAD on an explicit last bit or when the final key position fills.
    assign w_key_done = key_valid_i & (key_last_i | (r_bit_cnt == CNT_W'(KEY_W - 1)));

    prio_arbiter #(
        .NCH  (NCH),
        .ID_W (ID_W)
    ) u_arb (
        .req (w_req),
        .any (w_any),
        .id  (w_id)
    );

    // One-hot clear of the true (uncorrupted) granted channel on handshake.
    always_comb begin
        w_clr_vec = '0;
        for (int i = 0; i < NCH; i++) begin
            w_clr_vec[i] = w_hs & (r_true_id == ID_W'(i));
        end
    end

    // Pending register: set wins over the handshake clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr_vec) | irq_i;
        end
    end

    // Controller FSM: key shifter, key check, grant presentation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LOAD;
            r_key       <= '0;
            r_bit_cnt   <= '0;
            r_unlocked  <= 1'b0;
            r_key_ready <= 1'b1;
            r_int_valid <= 1'b0;
            r_int_id    <= '0;
            r_true_id   <= '0;
        end else if (key_clear_i) begin
            // Pending requests are kept; only the key context is discarded.
            r_state     <= LOAD;
            r_key       <= '0;
            r_bit_cnt   <= '0;
            r_unlocked  <= 1'b0;
            r_key_ready <= 1'b1;
            r_int_valid <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (key_valid_i) begin
                        for (int i = 0; i < KEY_W; i++) begin
                            if (r_bit_cnt == CNT_W'(i)) begin
                                r_key[i] <= key_bit_i;
                            end
                        end
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (w_key_done) begin
                            r_state     <= CHECK;
                            r_key_ready <= 1'b0;
                        end
                    end
                end
                CHECK: begin
                    r_unlocked <= (r_key == KEY_VAL);
                    r_state    <= RUN;
                end
                RUN: begin
                    if (r_int_valid) begin
                        if (int_ack_i) begin
                            r_int_valid <= 1'b0;
                        end
                    end else if (w_any) begin
                        // The key is frozen in RUN, so corruption is fixed at grant time.
                        r_int_valid <= 1'b1;
                        r_true_id   <= w_id;
                        r_int_id    <= w_id ^ (r_key[ID_W-1:0] ^ KEY_LOW);
                    end
                end
                default: begin
                    r_state     <= LOAD;
                    r_key_ready <= 1'b1;
                end
            endcase
        end
    end

    assign key_ready_o = r_key_ready;
    assign unlocked_o  = r_unlocked;
    assign int_valid_o = r_int_valid;
    assign int_id_o    = r_int_id;

endmodule
